// File: rtl/ysyx_23060208_uart_pkg.sv
// Shared definitions for the AXI-Lite UART transmitter: register offsets,
// response codes and the state encodings of its three FSMs.
package ysyx_23060208_uart_pkg;

  localparam logic [1:0] OFF_TXDATA  = 2'd0;
  localparam logic [1:0] OFF_STATUS  = 2'd1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_RESP} r_state_t;
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} s_state_t;

endpackage

// File: rtl/ysyx_23060208_sync_fifo.sv
// Single-clock FIFO with occupancy count; full/empty are derived from the
// count, so a push while full is rejected even if a pop happens that cycle.
module ysyx_23060208_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ysyx_23060208_uart_axil.sv
// AXI-Lite slave feeding a TX FIFO and an 8N1 UART serializer.
// Registers: 0x0 TXDATA (write-only), 0x4 STATUS (read-only).
module ysyx_23060208_uart_axil
  import ysyx_23060208_uart_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int CLK_DIV    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] awaddr,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [3:0]            wstrb,
  input  logic                  wvalid,
  output logic                  wready,
  output logic [1:0]            bresp,
  output logic                  bvalid,
  input  logic                  bready,
  input  logic [DATA_WIDTH-1:0] araddr,
  input  logic                  arvalid,
  output logic                  arready,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [1:0]            rresp,
  output logic                  rvalid,
  input  logic                  rready,
  output logic                  uart_tx,
  output logic                  tx_irq
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int CYC_W = $clog2(CLK_DIV);

  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]       fifo_din, fifo_dout;
  logic [CNT_W-1:0] fifo_count;

  ysyx_23060208_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  logic unused_bits;
  assign unused_bits = ^{awaddr[DATA_WIDTH-1:4], awaddr[1:0], araddr[DATA_WIDTH-1:4],
                         araddr[1:0], wdata[DATA_WIDTH-1:8], wstrb[3:1]};

  w_state_t   w_state, w_next;
  logic       aw_held, w_held, wstrb0_q, w_commit, w_strb0;
  logic [1:0] aw_off_q, w_off, w_resp, bresp_q;
  logic [7:0] wbyte_q;

  assign awready  = (w_state == W_IDLE);
  assign wready   = (w_state == W_IDLE);
  assign bvalid   = (w_state == W_RESP);
  assign bresp    = bresp_q;
  assign w_commit = (w_state == W_IDLE) && (awvalid || aw_held) && (wvalid || w_held);

  // A beat arriving in the commit cycle takes priority over a latched one
  always_comb begin
    w_next    = w_state;
    w_off     = awvalid ? awaddr[3:2] : aw_off_q;
    fifo_din  = wvalid ? wdata[7:0] : wbyte_q;
    w_strb0   = wvalid ? wstrb[0] : wstrb0_q;
    w_resp    = RESP_SLVERR;
    fifo_push = 1'b0;
    case (w_state)
      W_IDLE:  if (w_commit) w_next = W_RESP;
      W_RESP:  if (bready) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
    if (w_off == OFF_TXDATA) begin
      if (!w_strb0) begin
        w_resp = RESP_OKAY;
      end else if (!fifo_full) begin
        w_resp    = RESP_OKAY;
        fifo_push = w_commit;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) w_state <= W_IDLE;
    else     w_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      aw_off_q <= '0;
      wbyte_q  <= '0;
      wstrb0_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
    end else if (w_commit) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      bresp_q <= w_resp;
    end else if (w_state == W_IDLE) begin
      if (awvalid) begin
        aw_held  <= 1'b1;
        aw_off_q <= awaddr[3:2];
      end
      if (wvalid) begin
        w_held   <= 1'b1;
        wbyte_q  <= wdata[7:0];
        wstrb0_q <= wstrb[0];
      end
    end
  end

  s_state_t        s_state, s_next;
  logic [CYC_W-1:0] cyc_cnt, cyc_next;
  logic [2:0]       bit_cnt, bit_next;
  logic [7:0]       shreg, shreg_next;
  logic             tx_busy, bit_end;

  assign tx_busy = (s_state != S_IDLE);
  assign tx_irq  = fifo_empty && !tx_busy;
  assign bit_end = (cyc_cnt == CYC_W'(CLK_DIV - 1));

  r_state_t              r_state, r_next;
  logic [DATA_WIDTH-1:0] rdata_d;
  logic [1:0]            rresp_d;

  assign arready = (r_state == R_IDLE);
  assign rvalid  = (r_state == R_RESP);

  always_comb begin
    r_next  = r_state;
    rdata_d = '0;
    rresp_d = RESP_OKAY;
    case (r_state)
      R_IDLE:  if (arvalid) r_next = R_RESP;
      R_RESP:  if (rready) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
    if (araddr[3:2] == OFF_STATUS) begin
      rdata_d[0]    = fifo_full;
      rdata_d[1]    = fifo_empty;
      rdata_d[2]    = tx_busy;
      rdata_d[15:8] = 8'(fifo_count);
    end else if (araddr[3:2] != OFF_TXDATA) begin
      rresp_d = RESP_SLVERR;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= R_IDLE;
    else     r_state <= r_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
      rresp <= RESP_OKAY;
    end else if (r_state == R_IDLE && arvalid) begin
      rdata <= rdata_d;
      rresp <= rresp_d;
    end
  end

  // The stop bit's last cycle reloads directly so frames can run back-to-back
  always_comb begin
    s_next     = s_state;
    cyc_next   = cyc_cnt;
    bit_next   = bit_cnt;
    shreg_next = shreg;
    fifo_pop   = 1'b0;
    case (s_state)
      S_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          shreg_next = fifo_dout;
          cyc_next   = '0;
          s_next     = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          cyc_next = '0;
          bit_next = '0;
          s_next   = S_DATA;
        end else begin
          cyc_next = cyc_cnt + 1'b1;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          cyc_next   = '0;
          shreg_next = shreg >> 1;
          if (bit_cnt == 3'd7) s_next = S_STOP;
          else                 bit_next = bit_cnt + 1'b1;
        end else begin
          cyc_next = cyc_cnt + 1'b1;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          cyc_next = '0;
          bit_next = '0;
          if (!fifo_empty) begin
            fifo_pop   = 1'b1;
            shreg_next = fifo_dout;
            s_next     = S_START;
          end else begin
            s_next = S_IDLE;
          end
        end else begin
          cyc_next = cyc_cnt + 1'b1;
        end
      end
      default: s_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_state <= S_IDLE;
      cyc_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
    end else begin
      s_state <= s_next;
      cyc_cnt <= cyc_next;
      bit_cnt <= bit_next;
      shreg   <= shreg_next;
    end
  end

  always_comb begin
    uart_tx = 1'b1;
    case (s_state)
      S_START: uart_tx = 1'b0;
      S_DATA:  uart_tx = shreg[0];
      default: uart_tx = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_ysyx_23060208_uart_axil.sv
// Randomized self-checking bench: a line monitor decodes every frame and
// compares it against a queue of bytes the bench expects to be sent.
module tb_ysyx_23060208_uart_axil;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int DIV   = 4;
  localparam int FRAME = 10 * DIV;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] awaddr, wdata, araddr, rdata;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rvalid, rready, uart_tx, tx_irq;
  logic [3:0]    wstrb;
  logic [1:0]    bresp, rresp;

  int          n_vectors = 0;
  int          n_miscompares = 0;
  int          cyc = 0;
  logic        mon_en = 1'b1;
  logic [7:0]  exp_q[$];
  int          start_q[$];

  ysyx_23060208_uart_axil #(
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (DEPTH),
    .CLK_DIV    (DIV)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .awaddr  (awaddr),
    .awvalid (awvalid),
    .awready (awready),
    .wdata   (wdata),
    .wstrb   (wstrb),
    .wvalid  (wvalid),
    .wready  (wready),
    .bresp   (bresp),
    .bvalid  (bvalid),
    .bready  (bready),
    .araddr  (araddr),
    .arvalid (arvalid),
    .arready (arready),
    .rdata   (rdata),
    .rresp   (rresp),
    .rvalid  (rvalid),
    .rready  (rready),
    .uart_tx (uart_tx),
    .tx_irq  (tx_irq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    n_vectors++;
    if (actual !== expected) begin
      n_miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Line waveform of one 8N1 frame, one entry per clock cycle
  function automatic logic [39:0] frameOf(input logic [7:0] b);
    logic [39:0] f;
    for (int c = 0; c < FRAME; c++) begin
      if (c < DIV)          f[c] = 1'b0;
      else if (c < 9 * DIV) f[c] = b[(c - DIV) / DIV];
      else                  f[c] = 1'b1;
    end
    return f;
  endfunction

  function automatic logic [31:0] statusWord(input int count, input logic busy);
    logic [31:0] s;
    s       = '0;
    s[15:8] = 8'(count);
    s[2]    = busy;
    s[1]    = (count == 0);
    s[0]    = (count == DEPTH);
    return s;
  endfunction

  function automatic logic [31:0] randAddr(input logic [1:0] off);
    return (32'($urandom) & 32'hFFFF_FFF3) | {28'd0, off, 2'b00};
  endfunction

  task automatic applyStimulus(input logic [1:0] off, input logic [7:0] data, input logic [3:0] strb,
                               input int w_lead, input int bhold, input logic [1:0] exp_resp);
    int t;
    wdata = {24'($urandom), data};
    wstrb = strb;
    if (w_lead > 0) begin
      wvalid = 1'b1;
      @(posedge clk); #1;
      wvalid = 1'b0;
      repeat (w_lead - 1) begin @(posedge clk); #1; end
    end
    awaddr  = randAddr(off);
    awvalid = 1'b1;
    wvalid  = (w_lead == 0);
    @(posedge clk); #1;
    awvalid = 1'b0;
    wvalid  = 1'b0;
    checkOutput("bvalid_latency", bvalid, 1);
    t = 0;
    while (!bvalid && t < 20) begin @(posedge clk); #1; t++; end
    for (int i = 0; i < bhold; i++) begin
      checkOutput("bvalid_hold", bvalid, 1);
      checkOutput("bresp_hold", bresp, exp_resp);
      checkOutput("awready_in_resp", awready, 0);
      @(posedge clk); #1;
    end
    checkOutput("bresp", bresp, exp_resp);
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    checkOutput("bvalid_drop", bvalid, 0);
  endtask

  task automatic applyRead(input logic [1:0] off, input logic [31:0] exp_data,
                           input logic [1:0] exp_resp, input string tag);
    araddr  = randAddr(off);
    arvalid = 1'b1;
    @(posedge clk); #1;
    arvalid = 1'b0;
    checkOutput({tag, "_rvalid"}, rvalid, 1);
    @(posedge clk); #1;
    checkOutput({tag, "_rdata"}, rdata, exp_data);
    checkOutput({tag, "_rresp"}, rresp, exp_resp);
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
    checkOutput({tag, "_rvalid_drop"}, rvalid, 0);
  endtask

  task automatic waitIdle();
    int t;
    t = 0;
    while (!tx_irq && t < 2000) begin @(posedge clk); #1; t++; end
    checkOutput("idle_timeout", tx_irq, 1);
    repeat (2) begin @(posedge clk); #1; end
  endtask

  initial begin : monitor
    logic [39:0] seen;
    logic [7:0]  b;
    forever begin
      @(negedge clk);
      if (mon_en && !rst && uart_tx === 1'b0) begin
        start_q.push_back(cyc);
        seen    = '0;
        seen[0] = uart_tx;
        for (int c = 1; c < FRAME; c++) begin
          @(negedge clk);
          seen[c] = uart_tx;
        end
        if (exp_q.size() == 0) begin
          checkOutput("frame_unexpected", 64'(seen), 64'hFF_FFFF_FFFF);
        end else begin
          b = exp_q.pop_front();
          checkOutput("frame", 64'(seen), 64'(frameOf(b)));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    logic [7:0]  b, a;
    logic [39:0] fa;
    logic [1:0]  off, resp;
    logic [3:0]  strb;
    int          s0;

    awaddr = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0; bready = 0;
    araddr = '0; arvalid = 0; rready = 0;
    rst = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    checkOutput("rst_awready", awready, 1);
    checkOutput("rst_wready", wready, 1);
    checkOutput("rst_arready", arready, 1);
    checkOutput("rst_bvalid", bvalid, 0);
    checkOutput("rst_rvalid", rvalid, 0);
    checkOutput("rst_bresp", bresp, 0);
    checkOutput("rst_rresp", rresp, 0);
    checkOutput("rst_rdata", rdata, 0);
    checkOutput("rst_uart_tx", uart_tx, 1);
    checkOutput("rst_tx_irq", tx_irq, 1);
    rst = 1'b0;
    @(posedge clk); #1;

    $display("[TB] 0x55 with AW and W together");
    exp_q.push_back(8'h55);
    applyStimulus(2'd0, 8'h55, 4'b0001, 0, 0, OKAY);
    checkOutput("irq_while_busy", tx_irq, 0);
    waitIdle();

    $display("[TB] W leads AW by 3 cycles, bready held off 5 cycles");
    b = 8'($urandom);
    exp_q.push_back(b);
    applyStimulus(2'd0, b, 4'hF, 3, 5, OKAY);
    applyRead(2'd1, statusWord(0, 1'b1), OKAY, "status_single_push");
    waitIdle();

    $display("[TB] six back-to-back writes");
    s0 = start_q.size();
    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom);
      if (i < DEPTH + 1) exp_q.push_back(b);
      applyStimulus(2'd0, b, {3'($urandom), 1'b1}, 0, 0, (i < DEPTH + 1) ? OKAY : SLVERR);
    end
    waitIdle();
    checkOutput("frames_b2b", start_q.size() - s0, DEPTH + 1);
    for (int i = s0 + 1; i < start_q.size(); i++)
      checkOutput("frame_gap", start_q[i] - start_q[i-1], FRAME);

    $display("[TB] STATUS while busy with two queued");
    for (int i = 0; i < 3; i++) begin
      b = 8'($urandom);
      exp_q.push_back(b);
      applyStimulus(2'd0, b, 4'b0001, 0, 0, OKAY);
    end
    applyRead(2'd1, statusWord(2, 1'b1), OKAY, "status_busy");
    applyRead(2'd2, 32'h0, SLVERR, "read_unmapped8");
    applyRead(2'd3, 32'h0, SLVERR, "read_unmappedC");
    applyRead(2'd0, 32'h0, OKAY, "read_txdata");
    waitIdle();

    $display("[TB] writes that must not push");
    applyStimulus(2'd1, 8'($urandom), 4'hF, 0, 0, SLVERR);
    applyStimulus(2'd0, 8'($urandom), 4'b0000, 0, 0, OKAY);
    applyStimulus(2'd2, 8'($urandom), 4'hF, 1, 1, SLVERR);
    checkOutput("irq_no_push", tx_irq, 1);
    applyRead(2'd1, statusWord(0, 1'b0), OKAY, "status_no_push");

    $display("[TB] random single writes");
    for (int k = 0; k < 10; k++) begin
      off  = 2'($urandom_range(0, 3));
      strb = 4'($urandom);
      b    = 8'($urandom);
      if (off == 2'd0) begin
        resp = OKAY;
        if (strb[0]) exp_q.push_back(b);
      end else begin
        resp = SLVERR;
      end
      applyStimulus(off, b, strb, $urandom_range(0, 3), $urandom_range(0, 3), resp);
      waitIdle();
    end

    $display("[TB] reset on cycle 12 of a frame");
    mon_en = 1'b0;
    a = 8'($urandom);
    applyStimulus(2'd0, a, 4'b0001, 0, 0, OKAY);
    checkOutput("frame_cycle1", uart_tx, 0);
    applyStimulus(2'd0, 8'($urandom), 4'b0001, 0, 0, OKAY);
    repeat (9) begin @(posedge clk); #1; end
    fa = frameOf(a);
    checkOutput("tx_cycle12", uart_tx, fa[11]);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("abort_uart_tx", uart_tx, 1);
    checkOutput("abort_tx_irq", tx_irq, 1);
    repeat (3) begin @(posedge clk); #1; end
    checkOutput("abort_tx_hold", uart_tx, 1);
    applyRead(2'd1, 32'h0000_0002, OKAY, "status_after_rst");
    mon_en = 1'b1;

    checkOutput("frames_pending", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule

// File: doc/ysyx_23060208_uart_axil.md
YSYX_23060208_UART_AXIL -- requirements
Module: ysyx_23060208_uart_axil

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, AXI-Lite address/data width.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, TX FIFO entries; power of two, at least 2.
REQ-003 SHALL have parameter CLK_DIV, default 16, clk cycles per serial bit; at least 2.
REQ-004 SHALL have ports: clk input 1, clock; rst input 1, reset (synchronous, active-high).
REQ-005 SHALL have ports: awaddr input DATA_WIDTH, awvalid input 1, awready output 1 (write address channel).
REQ-006 SHALL have ports: wdata input DATA_WIDTH, wstrb input 4, wvalid input 1, wready output 1 (write data channel).
REQ-007 SHALL have ports: bresp output 2, bvalid output 1, bready input 1 (write response channel).
REQ-008 SHALL have ports: araddr input DATA_WIDTH, arvalid input 1, arready output 1 (read address channel).
REQ-009 SHALL have ports: rdata output DATA_WIDTH, rresp output 2, rvalid output 1, rready input 1 (read data channel).
REQ-010 SHALL have ports: uart_tx output 1, serial line; tx_irq output 1, high while the FIFO is empty and the serializer is idle.

Function
REQ-011 Address decode SHALL use awaddr/araddr[3:2] only: 0 = TXDATA (write-only), 1 = STATUS (read-only), 2 and 3 = unmapped.
REQ-012 Write FSM states SHALL be W_IDLE and W_RESP. awready and wready SHALL be 1 in W_IDLE.
REQ-013 AW and W SHALL be accepted independently and latched. The write SHALL commit on the edge where both are held; the FSM enters W_RESP and bvalid = 1 on the next cycle.
REQ-014 A TXDATA commit with wstrb[0] = 1 and FIFO not full SHALL push wdata[7:0]; bresp = 00.
REQ-015 A TXDATA commit with the FIFO full SHALL drop the byte with bresp = 10 (SLVERR).
REQ-016 A TXDATA commit with wstrb[0] = 0 SHALL push nothing; bresp = 00.
REQ-017 A write to STATUS or an unmapped offset SHALL have no effect; bresp = 10.
REQ-018 In W_RESP, awready and wready SHALL be 0. bvalid and bresp SHALL stay stable until bready; the bvalid&&bready edge returns the FSM to W_IDLE.
REQ-019 Read FSM states SHALL be R_IDLE (arready = 1) and R_RESP (rvalid = 1). The arvalid handshake SHALL register rdata/rresp, and rvalid SHALL rise the next cycle.
REQ-020 rdata and rresp SHALL hold until rready; the rvalid&&rready edge returns the FSM to R_IDLE.
REQ-021 STATUS read data SHALL be: bit0 full, bit1 empty, bit2 tx_busy, bits[15:8] FIFO count, other bits 0; rresp = 00.
REQ-022 A TXDATA read SHALL return 0 with rresp = 00. An unmapped read SHALL return 0 with rresp = 10.
REQ-023 Serializer states SHALL be S_IDLE, S_START, S_DATA, S_STOP. tx_busy SHALL be 1 whenever the state is not S_IDLE.
REQ-024 In S_IDLE with the FIFO non-empty, the serializer SHALL pop on that edge and enter S_START; uart_tx = 0 SHALL start the following cycle.
REQ-025 Each state (and each of the 8 data bits in S_DATA) SHALL last exactly CLK_DIV cycles. Data SHALL go out LSB first, then uart_tx = 1 in S_STOP.
REQ-026 One frame SHALL be exactly 10*CLK_DIV cycles.
REQ-027 At the end of S_STOP with the FIFO non-empty, the serializer SHALL pop and go directly to S_START (back-to-back frames, no idle gap). With the FIFO empty it SHALL go to S_IDLE.
REQ-028 Simultaneous push and pop SHALL leave the count unchanged. Full is evaluated before the pop, so a push on a full FIFO in the pop cycle is still rejected (REQ-015).
REQ-029 FIFO pointers SHALL wrap modulo FIFO_DEPTH. Count width SHALL be $clog2(FIFO_DEPTH)+1.
REQ-030 uart_tx SHALL be 1 in S_IDLE.

Reset
REQ-031 On rst, the write FSM SHALL be W_IDLE and the read FSM R_IDLE.
REQ-032 On rst, the serializer SHALL be S_IDLE, the FIFO empty, and the bit and cycle counters 0.
REQ-033 Output reset values SHALL be: awready = 1, wready = 1, arready = 1, bvalid = 0, rvalid = 0, bresp = 00, rresp = 00, rdata = 0, uart_tx = 1, tx_irq = 1.
REQ-034 rst asserted mid-frame SHALL abort the frame: uart_tx = 1 the next cycle and FIFO contents discarded.

Structure
REQ-035 Package ysyx_23060208_uart_pkg SHALL hold the register offsets, the bresp/rresp codes (OKAY = 00, SLVERR = 10), and the write/read/serializer state enums.
REQ-036 The FIFO SHALL be a sub-module ysyx_23060208_sync_fifo, parametrised by width (8) and depth, with push, pop, full, empty and count ports.

Verification (FIFO_DEPTH = 4, CLK_DIV = 4)
REQ-037 Scenario: write 0x55 to 0x0 with AW and W in the same cycle. Required: bvalid one cycle later with bresp = 00, and 40 cycles of uart_tx = 0,1,0,1,0,1,0,1,0,1, each held 4 cycles.
REQ-038 Scenario: W issued 3 cycles before AW, bready held low 5 cycles. Required: a single push, and bvalid/bresp stable for all 5 cycles.
REQ-039 Scenario: 6 back-to-back writes while a frame is in progress. Required: first 5 bresp = 00 (1 in serializer plus 4 in FIFO), 6th bresp = 10, and 5 contiguous frames with no idle gap.
REQ-040 Scenario: read 0x4 with the FIFO holding 2 bytes and busy. Required: rdata = 0x00000204, rresp = 00. Read 0x8 returns rdata = 0, rresp = 10.
REQ-041 Scenario: rst asserted on cycle 12 of a frame. Required: uart_tx = 1 the next cycle; STATUS afterwards reads 0x00000002; tx_irq = 1.
REQ-042 Scenario: write to 0x4, and write to 0x0 with wstrb = 0000. Required: both give no push; bresp = 10 and 00 respectively.
